// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - register offsets and address-window constants for gpio_irq
package gpio_irq_pkg;

    localparam logic [4:0] OFF_IN      = 5'h00;
    localparam logic [4:0] OFF_OUT     = 5'h04;
    localparam logic [4:0] OFF_DIR     = 5'h08;
    localparam logic [4:0] OFF_SET     = 5'h0C;
    localparam logic [4:0] OFF_CLR     = 5'h10;
    localparam logic [4:0] OFF_RISE_EN = 5'h14;
    localparam logic [4:0] OFF_FALL_EN = 5'h18;
    localparam logic [4:0] OFF_STATUS  = 5'h1C;

    // Address bits [31:5] select the 32-byte register window.
    localparam int WIN_CMP_W = 27;

endpackage

// File: rtl/gpio_edge_sync.sv
// rtl/gpio_edge_sync.sv - pad input synchroniser chain with rise/fall edge detection
module gpio_edge_sync #(
    parameter int nrOfPins = 8,
    parameter int nrOfSync = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [nrOfPins-1:0] pinsIn,
    output logic [nrOfPins-1:0] syncIn,
    output logic [nrOfPins-1:0] rise,
    output logic [nrOfPins-1:0] fall
);

    logic [nrOfSync-1:0][nrOfPins-1:0] chain_q;
    logic [nrOfPins-1:0]               prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[nrOfSync-2:0], pinsIn};
            prev_q  <= chain_q[nrOfSync-1];
        end
    end

    assign syncIn = chain_q[nrOfSync-1];
    assign rise   = syncIn & ~prev_q;
    assign fall   = ~syncIn & prev_q;

endmodule

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - bus-attached GPIO block with atomic set/clear and edge interrupts
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int          nrOfPins = 8,
    parameter int          nrOfSync = 2,
    parameter logic [31:0] Base     = 32'h40000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [nrOfPins-1:0] pinsIn,
    output logic [nrOfPins-1:0] pinsOut,
    output logic [nrOfPins-1:0] pinsOutEnable,
    output logic                irqOut,
    input  logic                beginTransactionIn,
    input  logic                endTransactionIn,
    input  logic                readNotWriteIn,
    input  logic                dataValidIn,
    input  logic                busErrorIn,
    input  logic                busyIn,
    input  logic [31:0]         addressDataIn,
    input  logic [3:0]          byteEnablesIn,
    input  logic [7:0]          burstSizeIn,
    output logic                endTransactionOut,
    output logic                dataValidOut,
    output logic                busErrorOut,
    output logic [31:0]         addressDataOut
);

    logic [nrOfPins-1:0] sync_in, rise, fall;

    gpio_edge_sync #(
        .nrOfPins (nrOfPins),
        .nrOfSync (nrOfSync)
    ) u_edge_sync (
        .clock  (clock),
        .reset  (reset),
        .pinsIn (pinsIn),
        .syncIn (sync_in),
        .rise   (rise),
        .fall   (fall)
    );

    logic        rnw_q, active_q, first_q;
    logic [31:2] addr_q;
    logic [3:0]  be_q;
    logic [7:0]  burst_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rnw_q    <= 1'b0;
            active_q <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            burst_q  <= '0;
        end else begin
            first_q <= beginTransactionIn;
            if (beginTransactionIn) begin
                rnw_q    <= readNotWriteIn;
                addr_q   <= addressDataIn[31:2];
                be_q     <= byteEnablesIn;
                burst_q  <= burstSizeIn;
                active_q <= 1'b1;
            end else if (endTransactionIn) begin
                active_q <= 1'b0;
            end
        end
    end

    logic                hit, legal, wr_en, rd_go;
    logic [4:0]          reg_off;
    logic [nrOfPins-1:0] wdata;

    assign hit         = addr_q[31:32-WIN_CMP_W] == Base[31:32-WIN_CMP_W];
    assign legal       = (be_q == 4'hF) && (burst_q == 8'd0);
    assign busErrorOut = hit & active_q & ~legal;
    assign wr_en       = active_q & ~rnw_q & hit & legal & dataValidIn;
    // Only the first active cycle launches a read; later cycles just hold it.
    assign rd_go       = first_q & active_q & rnw_q & hit & legal;
    assign reg_off     = {addr_q[4:2], 2'b00};
    assign wdata       = addressDataIn[nrOfPins-1:0];

    logic [nrOfPins-1:0] out_q, out_d, dir_q, dir_d;
    logic [nrOfPins-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [nrOfPins-1:0] status_q, status_d, w1c;
    logic                irq_q;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_en) begin
            case (reg_off)
                OFF_OUT:     out_d     = wdata;
                OFF_DIR:     dir_d     = wdata;
                OFF_SET:     out_d     = out_q | wdata;
                OFF_CLR:     out_d     = out_q & ~wdata;
                OFF_RISE_EN: rise_en_d = wdata;
                OFF_FALL_EN: fall_en_d = wdata;
                OFF_STATUS:  w1c       = wdata;
                default:     ;
            endcase
        end
        // New edges are ORed in after the clear so a coincident edge survives.
        status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= |status_q;
        end
    end

    assign pinsOut       = out_q;
    assign pinsOutEnable = dir_q;
    assign irqOut        = irq_q;

    logic [nrOfPins-1:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OFF_IN:      rd_val = sync_in;
            OFF_OUT:     rd_val = out_q;
            OFF_DIR:     rd_val = dir_q;
            OFF_RISE_EN: rd_val = rise_en_q;
            OFF_FALL_EN: rd_val = fall_en_q;
            OFF_STATUS:  rd_val = status_q;
            default:     rd_val = '0;
        endcase
    end

    logic        dv_q, dv_d, end_q, end_d, dv_hold;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        dv_hold = dv_q & busyIn;
        dv_d    = rd_go | dv_hold;
        rdata_d = '0;
        if (rd_go) begin
            rdata_d = 32'(rd_val);
        end else if (dv_hold) begin
            rdata_d = rdata_q;
        end
        end_d = dv_q & ~busyIn;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dv_q    <= 1'b0;
            rdata_q <= '0;
            end_q   <= 1'b0;
        end else begin
            dv_q    <= dv_d;
            rdata_q <= rdata_d;
            end_q   <= end_d;
        end
    end

    assign dataValidOut      = dv_q;
    assign addressDataOut    = rdata_q;
    assign endTransactionOut = end_q;

    logic unused_bits;
    assign unused_bits = ^{busErrorIn, addressDataIn};

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - scoreboard testbench for gpio_irq
module tb_gpio_irq;

    localparam logic [31:0] BASE = 32'h40000000;
    localparam logic [31:0] O_IN = 32'h00, O_OUT = 32'h04, O_DIR = 32'h08, O_SET = 32'h0C;
    localparam logic [31:0] O_CLR = 32'h10, O_REN = 32'h14, O_FEN = 32'h18, O_STAT = 32'h1C;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  pinsIn, pinsOut, pinsOutEnable;
    logic        irqOut;
    logic        beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn, busErrorIn, busyIn;
    logic [31:0] addressDataIn, addressDataOut;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        endTransactionOut, dataValidOut, busErrorOut;

    gpio_irq #(.nrOfPins(8), .nrOfSync(2), .Base(BASE)) dut (
        .clock              (clock),
        .reset              (reset),
        .pinsIn             (pinsIn),
        .pinsOut            (pinsOut),
        .pinsOutEnable      (pinsOutEnable),
        .irqOut             (irqOut),
        .beginTransactionIn (beginTransactionIn),
        .endTransactionIn   (endTransactionIn),
        .readNotWriteIn     (readNotWriteIn),
        .dataValidIn        (dataValidIn),
        .busErrorIn         (busErrorIn),
        .busyIn             (busyIn),
        .addressDataIn      (addressDataIn),
        .byteEnablesIn      (byteEnablesIn),
        .burstSizeIn        (burstSizeIn),
        .endTransactionOut  (endTransactionOut),
        .dataValidOut       (dataValidOut),
        .busErrorOut        (busErrorOut),
        .addressDataOut     (addressDataOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                             input logic [7:0] burst, input logic exp_err, input string name);
        @(posedge clock); #1;
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b0; addressDataIn = addr;
        byteEnablesIn = be; burstSizeIn = burst;
        @(posedge clock); #1;
        beginTransactionIn = 1'b0; addressDataIn = data; dataValidIn = 1'b1; endTransactionIn = 1'b1;
        @(negedge clock);
        check(name, {31'd0, busErrorOut}, {31'd0, exp_err});
        @(posedge clock); #1;
        dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst,
                            input int busy_n, input logic exp_err, input string name);
        @(posedge clock); #1;
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; addressDataIn = addr;
        byteEnablesIn = be; burstSizeIn = burst;
        @(posedge clock); #1;
        beginTransactionIn = 1'b0; endTransactionIn = 1'b1; addressDataIn = '0;
        @(negedge clock);
        check(name, {31'd0, busErrorOut}, {31'd0, exp_err});
        @(posedge clock); #1;
        endTransactionIn = 1'b0;
        busyIn = (busy_n > 0);
        repeat (busy_n) begin
            @(posedge clock); #1;
        end
        busyIn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        bus_write(BASE + off, data, 4'hF, 8'd0, 1'b0, "wr_buserr");
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp, input int busy_n);
        exp_q.push_back('{data: exp, cycles: busy_n + 1});
        bus_read(BASE + off, 4'hF, 8'd0, busy_n, 1'b0, "rd_buserr");
    endtask

    // Read-response monitor: pops one expectation per dataValidOut burst.
    initial begin : monitor
        bit   in_burst = 0;
        bit   end_ok;
        int   cnt = 0;
        exp_t cur;
        forever begin
            @(negedge clock);
            end_ok = 0;
            if (!reset) begin
                in_burst = 0;
                cnt = 0;
            end else begin
                if (dataValidOut) begin
                    if (!in_burst) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL rd_unexpected: got data 0x%0h expected no response", addressDataOut);
                            cur = '{data: addressDataOut, cycles: 0};
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        in_burst = 1;
                        cnt = 0;
                    end
                    cnt++;
                    check("rd_data", addressDataOut, cur.data);
                end else if (in_burst) begin
                    in_burst = 0;
                    if (cur.cycles != 0) check("rd_valid_cycles", cnt, cur.cycles);
                    check("rd_end_pulse", {31'd0, endTransactionOut}, 32'd1);
                    end_ok = 1;
                end
                if (endTransactionOut && !end_ok) check("rd_end_stray", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        reset = 1'b0; pinsIn = '0;
        beginTransactionIn = 0; endTransactionIn = 0; readNotWriteIn = 0; dataValidIn = 0;
        busErrorIn = 0; busyIn = 0; addressDataIn = '0; byteEnablesIn = '0; burstSizeIn = '0;
        #22;
        check("rst_pinsOut", {24'd0, pinsOut}, 32'd0);
        check("rst_pinsOutEnable", {24'd0, pinsOutEnable}, 32'd0);
        check("rst_irq", {31'd0, irqOut}, 32'd0);
        check("rst_dv", {31'd0, dataValidOut}, 32'd0);
        check("rst_end", {31'd0, endTransactionOut}, 32'd0);
        check("rst_data", addressDataOut, 32'd0);
        #1 reset = 1'b1;

        // Output register, atomic set/clear, direction.
        wr(O_OUT, 32'hA5);  @(negedge clock); check("out_write", {24'd0, pinsOut}, 32'hA5);
        wr(O_SET, 32'h0F);  @(negedge clock); check("out_set", {24'd0, pinsOut}, 32'hAF);
        wr(O_CLR, 32'h81);  @(negedge clock); check("out_clr", {24'd0, pinsOut}, 32'h2E);
        wr(O_SET, 32'h00);  @(negedge clock); check("out_set_zero", {24'd0, pinsOut}, 32'h2E);
        rd(O_OUT, 32'h2E, 0);
        rd(O_SET, 32'h00, 0);
        rd(O_CLR, 32'h00, 0);
        wr(O_DIR, 32'hFFFF_FF3C); @(negedge clock); check("dir_write", {24'd0, pinsOutEnable}, 32'h3C);
        rd(O_DIR, 32'h3C, 0);
        wr(O_IN, 32'hFF);
        rd(O_IN, 32'h00, 0);

        // Read held by busyIn for three cycles.
        rd(O_OUT, 32'h2E, 3);

        // Illegal and non-hit accesses.
        bus_write(BASE + O_OUT, 32'h00, 4'h3, 8'd0, 1'b1, "be_write_buserr");
        @(negedge clock); check("be_write_no_effect", {24'd0, pinsOut}, 32'h2E);
        bus_read(BASE + O_OUT, 4'hF, 8'd1, 0, 1'b1, "burst_read_buserr");
        bus_write(BASE + 32'h20 + O_OUT, 32'h00, 4'hF, 8'd0, 1'b0, "miss_write_buserr");
        bus_read(BASE + 32'h20 + O_OUT, 4'hF, 8'd0, 0, 1'b0, "miss_read_buserr");
        rd(O_OUT, 32'h2E, 0);

        // Rising edge on pin 0: STATUS after 3 clocks, irqOut after 4.
        wr(O_REN, 32'h01);
        @(posedge clock); #1 pinsIn[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 3) check("irq_not_yet", {31'd0, irqOut}, 32'd0);
            if (k == 4) check("irq_rise", {31'd0, irqOut}, 32'd1);
        end
        rd(O_STAT, 32'h01, 0);
        rd(O_IN, 32'h01, 0);
        wr(O_STAT, 32'h01);
        @(negedge clock); check("irq_after_w1c_lag", {31'd0, irqOut}, 32'd1);
        @(negedge clock); check("irq_cleared", {31'd0, irqOut}, 32'd0);
        rd(O_STAT, 32'h00, 0);

        // Falling edge on pin 7 coinciding with its W1C clear.
        wr(O_FEN, 32'h80);
        @(posedge clock); #1 pinsIn[7] = 1'b1;
        repeat (4) @(posedge clock);
        @(posedge clock); #1 pinsIn[7] = 1'b0;
        wr(O_STAT, 32'h80);
        rd(O_STAT, 32'h80, 0);
        wr(O_FEN, 32'h00);
        rd(O_STAT, 32'h80, 0);
        wr(O_STAT, 32'h80);
        rd(O_STAT, 32'h00, 0);
        wr(O_FEN, 32'h80);
        @(posedge clock); #1 pinsIn[7] = 1'b1;
        repeat (4) @(posedge clock);
        #1 pinsIn[7] = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock); check("irq_fall", {31'd0, irqOut}, 32'd1);

        // Reset asserted while a read is being held by busyIn.
        wr(O_OUT, 32'h5A);
        exp_q.push_back('{data: 32'h5A, cycles: 0});
        @(posedge clock); #1;
        beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; addressDataIn = BASE + O_OUT;
        byteEnablesIn = 4'hF; burstSizeIn = 8'd0;
        @(posedge clock); #1;
        beginTransactionIn = 1'b0; endTransactionIn = 1'b1; addressDataIn = '0;
        @(posedge clock); #1;
        endTransactionIn = 1'b0; busyIn = 1'b1;
        @(negedge clock);
        check("mid_rst_dv_before", {31'd0, dataValidOut}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_dv", {31'd0, dataValidOut}, 32'd0);
        check("mid_rst_data", addressDataOut, 32'd0);
        check("mid_rst_end", {31'd0, endTransactionOut}, 32'd0);
        check("mid_rst_pinsOut", {24'd0, pinsOut}, 32'd0);
        check("mid_rst_dir", {24'd0, pinsOutEnable}, 32'd0);
        check("mid_rst_irq", {31'd0, irqOut}, 32'd0);
        @(negedge clock); #2;
        reset = 1'b1; busyIn = 1'b0;
        rd(O_OUT, 32'h00, 0);
        rd(O_DIR, 32'h00, 0);
        rd(O_FEN, 32'h00, 0);
        rd(O_STAT, 32'h00, 0);
        rd(O_IN, 32'h01, 0);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
